// File: rtl/radix_4_ntt_scheduler.sv
// Radix-4 NTT/INTT address scheduler: walks L stages of n/4 butterflies and
// issues operand, twiddle and delayed write-back addresses for one PE.
module radix_4_ntt_scheduler #(
  parameter int N      = 17,
  parameter int L      = 4,
  parameter int PE_LAT = 3
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               inv,
  output logic                               busy,
  output logic                               done,
  output logic                               rd_en,
  output logic [2*L-1:0]                     rd_addr0,
  output logic [2*L-1:0]                     rd_addr1,
  output logic [2*L-1:0]                     rd_addr2,
  output logic [2*L-1:0]                     rd_addr3,
  output logic [((L > 1) ? 2*L-2 : 1)-1:0]   tf_addr,
  output logic                               pe_inv,
  output logic [2:0]                         stage,
  output logic                               wr_en,
  output logic [2*L-1:0]                     wr_addr0,
  output logic [2*L-1:0]                     wr_addr1,
  output logic [2*L-1:0]                     wr_addr2,
  output logic [2*L-1:0]                     wr_addr3,
  output logic [1:0]                         o_dbg_state
);

  localparam int AW = 2*L;
  // k and tf_addr need AW-2 bits; a single stage (L=1) still keeps one bit.
  localparam int KW = (L > 1) ? AW-2 : 1;
  localparam int Q  = 1 << (AW-2);
  localparam int D  = PE_LAT + 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  localparam logic [KW-1:0] K_LAST     = KW'(Q-1);
  localparam logic [3:0]    DRAIN_LAST = 4'(D-1);
  localparam logic [2:0]    S_LAST     = 3'(L-1);
  localparam logic [3:0]    TF_SH_MAX  = 4'(2*(L-1));
  localparam logic [31:0]   N_VEC      = 32'(N);

  logic [1:0]    r_state;
  logic [2:0]    r_s;
  logic [KW-1:0] r_k;
  logic [3:0]    r_drain_cnt;
  logic          r_pe_inv;

  // N only configures the PE; it is carried here for parameter plumbing.
  logic w_unused_cfg;
  assign w_unused_cfg = ^N_VEC;

  // Handshake: start is a one-cycle request taken only in IDLE (never
  // back-pressured); rd_en and wr_en are unacknowledged single-cycle strobes
  // whose address buses are valid only while the strobe is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_s         <= 3'd0;
      r_k         <= '0;
      r_drain_cnt <= 4'd0;
      r_pe_inv    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state     <= S_RUN;
            r_pe_inv    <= inv;
            r_s         <= 3'd0;
            r_k         <= '0;
            r_drain_cnt <= 4'd0;
          end
        end
        S_RUN: begin
          if (r_k == K_LAST) begin
            r_state     <= S_DRAIN;
            r_k         <= '0;
            r_drain_cnt <= 4'd0;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_drain_cnt <= 4'd0;
            if (r_s == S_LAST) begin
              r_state <= S_FINISH;
            end else begin
              r_s     <= r_s + 3'd1;
              r_state <= S_RUN;
            end
          end else begin
            r_drain_cnt <= r_drain_cnt + 4'd1;
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_s     <= 3'd0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done        = (r_state == S_FINISH);
  assign rd_en       = (r_state == S_RUN);
  assign pe_inv      = r_pe_inv;
  assign stage       = r_s;
  assign o_dbg_state = r_state;

  // With d = 4^s: j = k mod d is the low 2s bits, grp = k div d the rest;
  // base = grp*4d + j leaves bits [2s+1:2s] free for the operand index M.
  logic [3:0]    w_sh;
  logic [AW-1:0] w_k;
  logic [AW-1:0] w_mask;
  logic [AW-1:0] w_j;
  logic [AW-1:0] w_base;

  assign w_sh   = {r_s, 1'b0};
  assign w_k    = AW'(r_k);
  assign w_mask = (AW'(1) << w_sh) - AW'(1);
  assign w_j    = w_k & w_mask;
  assign w_base = ((w_k >> w_sh) << (w_sh + 4'd2)) | w_j;

  assign rd_addr0 = rd_en ? w_base                         : '0;
  assign rd_addr1 = rd_en ? (w_base | (AW'(1) << w_sh))    : '0;
  assign rd_addr2 = rd_en ? (w_base | (AW'(2) << w_sh))    : '0;
  assign rd_addr3 = rd_en ? (w_base | (AW'(3) << w_sh))    : '0;

  generate
    if (L > 1) begin : g_tf
      logic [KW-1:0] w_tf;
      assign w_tf    = KW'(w_j) << (TF_SH_MAX - w_sh);
      assign tf_addr = rd_en ? w_tf : '0;
    end else begin : g_tf_tie
      assign tf_addr = '0;
    end
  endgenerate

  // Write-back delay line: D = PE_LAT+1 covers the memory read plus the PE.
  logic              r_dl_en   [D];
  logic [4*AW-1:0]   r_dl_addr [D];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        r_dl_en[i]   <= 1'b0;
        r_dl_addr[i] <= '0;
      end
    end else begin
      r_dl_en[0]   <= rd_en;
      r_dl_addr[0] <= {rd_addr3, rd_addr2, rd_addr1, rd_addr0};
      for (int i = 1; i < D; i++) begin
        r_dl_en[i]   <= r_dl_en[i-1];
        r_dl_addr[i] <= r_dl_addr[i-1];
      end
    end
  end

  assign wr_en    = r_dl_en[D-1];
  assign wr_addr0 = r_dl_addr[D-1][AW-1:0];
  assign wr_addr1 = r_dl_addr[D-1][2*AW-1:AW];
  assign wr_addr2 = r_dl_addr[D-1][3*AW-1:2*AW];
  assign wr_addr3 = r_dl_addr[D-1][4*AW-1:3*AW];

endmodule

// File: tb/tb_radix_4_ntt_scheduler.sv
// Bench for radix_4_ntt_scheduler: randomized transforms checked cycle by
// cycle against an arithmetic model of the stage/butterfly schedule.
module tb_radix_4_ntt_scheduler;

  localparam int L        = 4;
  localparam int PE_LAT   = 3;
  localparam int AW       = 2*L;
  localparam int KW       = 2*L-2;
  localparam int NPTS     = 1 << AW;
  localparam int Q        = NPTS / 4;
  localparam int D        = PE_LAT + 1;
  localparam int P        = Q + D;
  localparam int BUSY_LEN = L * P;

  logic          clk;
  logic          rst;
  logic          start;
  logic          inv;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3;
  logic [KW-1:0] tf_addr;
  logic          pe_inv;
  logic [2:0]    stage;
  logic          wr_en;
  logic [AW-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
  logic [1:0]    dbg_state;

  radix_4_ntt_scheduler #(.N(17), .L(L), .PE_LAT(PE_LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .inv        (inv),
    .busy       (busy),
    .done       (done),
    .rd_en      (rd_en),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .rd_addr2   (rd_addr2),
    .rd_addr3   (rd_addr3),
    .tf_addr    (tf_addr),
    .pe_inv     (pe_inv),
    .stage      (stage),
    .wr_en      (wr_en),
    .wr_addr0   (wr_addr0),
    .wr_addr1   (wr_addr1),
    .wr_addr2   (wr_addr2),
    .wr_addr3   (wr_addr3),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [4*AW-1:0] exp_q[$];
  int              wcount[L][NPTS];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference schedule: cycle t after busy rises -> butterfly read, if any.
  function automatic void model_rd(input int t, output bit en,
                                   output logic [4*AW-1:0] addrs,
                                   output logic [KW-1:0] tf);
    int s, off, d, j, grp, base, tfm;
    en    = 1'b0;
    addrs = '0;
    tf    = '0;
    if (t >= 0 && t < BUSY_LEN) begin
      s   = t / P;
      off = t % P;
      if (off < Q) begin
        en = 1'b1;
        d  = 1;
        for (int i = 0; i < s; i++) d = d * 4;
        j    = off % d;
        grp  = off / d;
        base = grp * 4 * d + j;
        addrs = {AW'(base + 3*d), AW'(base + 2*d), AW'(base + d), AW'(base)};
        tfm = j;
        for (int i = 0; i < L-1-s; i++) tfm = tfm * 4;
        tf = KW'(tfm);
      end
    end
  endfunction

  task automatic check_cycle(input int t, input bit inv_exp);
    bit              en_r, en_w;
    logic [4*AW-1:0] a_r, a_w, w_exp;
    logic [KW-1:0]   tf_r, tf_w;
    int              ws;
    model_rd(t, en_r, a_r, tf_r);
    model_rd(t - D, en_w, a_w, tf_w);
    chk("busy", busy, t < BUSY_LEN);
    chk("done", done, t == BUSY_LEN);
    chk("rd_en", rd_en, en_r);
    chk("rd_addr", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, a_r);
    chk("tf_addr", tf_addr, tf_r);
    chk("wr_en", wr_en, en_w);
    if (en_r) exp_q.push_back(a_r);
    if (en_w) begin
      if (exp_q.size() == 0) chk("wr_q_depth", exp_q.size(), 1);
      else begin
        w_exp = exp_q.pop_front();
        chk("wr_addr", {wr_addr3, wr_addr2, wr_addr1, wr_addr0}, w_exp);
      end
    end else begin
      chk("wr_addr_idle", {wr_addr3, wr_addr2, wr_addr1, wr_addr0}, 0);
    end
    if (t < BUSY_LEN) begin
      chk("stage", stage, t / P);
      chk("pe_inv", pe_inv, inv_exp);
    end
    if (wr_en && t >= D) begin
      ws = (t - D) / P;
      if (ws < L) begin
        wcount[ws][wr_addr0]++;
        wcount[ws][wr_addr1]++;
        wcount[ws][wr_addr2]++;
        wcount[ws][wr_addr3]++;
      end
    end
  endtask

  // Driver: one transform, optional start/inv disturbance, optional abort.
  task automatic run_transform(input bit inv_v, input bit disturb, input int abort_at);
    int bad;
    exp_q.delete();
    foreach (wcount[s, a]) wcount[s][a] = 0;
    start = 1'b1;
    inv   = inv_v;
    chk("busy_pre", busy, 0);
    step();
    start = 1'b0;
    for (int t = 0; t <= BUSY_LEN; t++) begin
      check_cycle(t, inv_v);
      if (t == 0) begin
        chk("first_rd", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, {8'd3, 8'd2, 8'd1, 8'd0});
        chk("first_tf", tf_addr, 0);
      end
      if (t == P + 5) begin
        chk("s1_k5_rd", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, {8'd29, 8'd25, 8'd21, 8'd17});
        chk("s1_k5_tf", tf_addr, 16);
      end
      if (t == 3*P + 63) begin
        chk("s3_k63_rd", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, {8'd255, 8'd191, 8'd127, 8'd63});
        chk("s3_k63_tf", tf_addr, 63);
      end
      if (t == abort_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_rd_en", rd_en, 0);
        chk("abort_wr_en", wr_en, 0);
        chk("abort_done", done, 0);
        chk("abort_pe_inv", pe_inv, 0);
        chk("abort_stage", stage, 0);
        for (int c = 0; c < 20; c++) begin
          step();
          chk("abort_quiet", {busy, rd_en, wr_en, done}, 0);
        end
        return;
      end
      if (disturb && t < BUSY_LEN) begin
        start = 1'($urandom_range(0, 1));
        inv   = 1'($urandom_range(0, 1));
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("post_idle", {busy, done, rd_en, wr_en}, 0);
      chk("post_state", dbg_state, 0);
      step();
    end
    for (int s = 0; s < L; s++) begin
      bad = 0;
      for (int a = 0; a < NPTS; a++) if (wcount[s][a] != 1) bad++;
      chk($sformatf("wr_once_s%0d", s), bad, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    inv   = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_stage", stage, 0);
    chk("rst_pe_inv", pe_inv, 0);
    chk("rst_rd_addr", {rd_addr3, rd_addr2, rd_addr1, rd_addr0}, 0);
    chk("rst_wr_addr", {wr_addr3, wr_addr2, wr_addr1, wr_addr0}, 0);
    chk("rst_tf", tf_addr, 0);
    start = 1'b1;
    inv   = 1'b1;
    step();
    chk("rst_over_start_busy", busy, 0);
    chk("rst_over_start_inv", pe_inv, 0);
    start = 1'b0;
    inv   = 1'b0;
    rst   = 1'b0;
    step();
    step();
    chk("idle_hold", {busy, rd_en, dbg_state}, 0);

    run_transform(1'b0, 1'b0, -1);
    run_transform(1'b1, 1'b1, -1);
    run_transform(1'($urandom_range(0, 1)), 1'b0, 2*P + $urandom_range(0, Q-1));
    run_transform(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
